// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO feeds an LSB-first serialiser whose bit period is baud_div_i+1 clocks.
// Optional even-parity bit after the data bits when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps

module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_n_i,
  input  logic [DIV_W-1:0]              baud_div_i,
  input  logic                          wr_en_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  input  logic                          ovr_clr_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o,
  output logic                          overrun_o,
  output logic                          uart_tx
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int BCW   = $clog2(DATA_W);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               ovr_q, ovr_d;
  logic               push;
  logic               pop;
  logic               start_frame;
  logic               bit_end;
  logic [DATA_W-1:0]  head;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  // Full is judged on the pre-edge occupancy, so a push coinciding with a pop while full is dropped.
  always_comb begin
    push     = wr_en_i && !full_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (level_d == LVL_W'(FIFO_DEPTH));
    empty_d  = (level_d == '0);
    ovr_d    = (wr_en_i && full_q) || (ovr_q && !ovr_clr_i);
  end

  always_ff @(posedge sys_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    pop         = 1'b0;
    start_frame = 1'b0;
    bit_end     = (div_cnt_q == div_q);

    if (state_q != IDLE) begin
      div_cnt_d = bit_end ? '0 : div_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        if (!empty_q) begin
          start_frame = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BCW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d   = STOP;
            tx_d      = 1'b1;
            bit_cnt_d = '0;
`endif
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d   = STOP;
          tx_d      = 1'b1;
          bit_cnt_d = '0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == BCW'(STOP_BITS - 1)) begin
            if (!empty_q) begin
              start_frame = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase

    // Loading a frame also latches the divisor, so divisor changes only apply from the next frame.
    if (start_frame) begin
      pop       = 1'b1;
      state_d   = START;
      shift_d   = head;
      div_d     = baud_div_i;
      div_cnt_d = '0;
      bit_cnt_d = '0;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d  = ^head;
`endif
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovr_q     <= 1'b0;
      state_q   <= IDLE;
      div_q     <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovr_q     <= ovr_d;
      state_q   <= state_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign level_o   = level_q;
  assign busy_o    = busy_q;
  assign overrun_o = ovr_q;
  assign uart_tx   = tx_q;

endmodule
